// File: rtl/mem_access_unit.sv
// Data-memory access stage: runs a req/ack transaction per load or store,
// stalls the pipeline while busy, and registers formatted load data.
module mem_access_unit #(
   parameter int unsigned TIMEOUT = 200
) (
   input  logic        clk,
   input  logic        nrst,
   input  logic        i_MEM_ctrl_MemRead,
   input  logic        i_MEM_ctrl_MemWrite,
   input  logic [1:0]  i_MEM_ctrl_Size,
   input  logic        i_MEM_ctrl_Unsigned,
   input  logic [31:0] i_MEM_data_Addr,
   input  logic [31:0] i_MEM_data_WData,
   output logic        o_dmem_req,
   output logic        o_dmem_we,
   output logic [31:0] o_dmem_addr,
   output logic [3:0]  o_dmem_be,
   output logic [31:0] o_dmem_wdata,
   input  logic        i_dmem_ack,
   input  logic [31:0] i_dmem_rdata,
   output logic [31:0] o_MEM_data_MemData,
   output logic        o_stall,
   output logic        o_misalign,
   output logic        o_bus_err
);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t      state_q, state_d;
   logic        req_q, req_d, we_q, we_d;
   logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
   logic [3:0]  be_q, be_d;
   logic [1:0]  size_q, size_d, lane_q, lane_d;
   logic        uns_q, uns_d, load_q, load_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [31:0] mem_q, mem_d;
   logic        misalign_q, misalign_d, bus_err_q, bus_err_d;

   logic        access, misaligned, timeout_hit;
   logic [3:0]  be_fmt;
   logic [31:0] wdata_fmt, rdata_fmt;
   logic [7:0]  byte_v;
   logic [15:0] half_v;

   assign access     = i_MEM_ctrl_MemRead | i_MEM_ctrl_MemWrite;
   assign misaligned = ((i_MEM_ctrl_Size == 2'b01) & i_MEM_data_Addr[0]) |
                       (i_MEM_ctrl_Size[1] & (i_MEM_data_Addr[1:0] != 2'b00));
   assign timeout_hit = (state_q == BUSY) & (cnt_q == 8'(TIMEOUT - 1)) & ~i_dmem_ack;

   always_comb begin
      be_fmt    = 4'b1111;
      wdata_fmt = i_MEM_data_WData;
      case (i_MEM_ctrl_Size)
         2'b00: begin
            be_fmt    = 4'b0001 << i_MEM_data_Addr[1:0];
            wdata_fmt = {4{i_MEM_data_WData[7:0]}};
         end
         2'b01: begin
            be_fmt    = i_MEM_data_Addr[1] ? 4'b1100 : 4'b0011;
            wdata_fmt = {2{i_MEM_data_WData[15:0]}};
         end
         default: ;
      endcase
   end

   // Lane selection uses the byte offset captured at request time.
   always_comb begin
      byte_v    = 8'(i_dmem_rdata >> {lane_q, 3'b000});
      half_v    = lane_q[1] ? i_dmem_rdata[31:16] : i_dmem_rdata[15:0];
      rdata_fmt = i_dmem_rdata;
      case (size_q)
         2'b00:   rdata_fmt = uns_q ? {24'h0, byte_v} : {{24{byte_v[7]}}, byte_v};
         2'b01:   rdata_fmt = uns_q ? {16'h0, half_v} : {{16{half_v[15]}}, half_v};
         default: ;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      req_d      = req_q;
      we_d       = we_q;
      addr_d     = addr_q;
      be_d       = be_q;
      wdata_d    = wdata_q;
      size_d     = size_q;
      lane_d     = lane_q;
      uns_d      = uns_q;
      load_d     = load_q;
      cnt_d      = cnt_q;
      mem_d      = mem_q;
      misalign_d = 1'b0;
      bus_err_d  = 1'b0;
      o_stall    = 1'b0;
      case (state_q)
         IDLE: begin
            if (access) begin
               if (misaligned) begin
                  misalign_d = 1'b1;
               end else begin
                  o_stall = 1'b1;
                  req_d   = 1'b1;
                  we_d    = i_MEM_ctrl_MemWrite;
                  addr_d  = {i_MEM_data_Addr[31:2], 2'b00};
                  be_d    = be_fmt;
                  wdata_d = wdata_fmt;
                  size_d  = i_MEM_ctrl_Size;
                  lane_d  = i_MEM_data_Addr[1:0];
                  uns_d   = i_MEM_ctrl_Unsigned;
                  load_d  = ~i_MEM_ctrl_MemWrite;
                  cnt_d   = '0;
                  state_d = BUSY;
               end
            end
         end
         BUSY: begin
            o_stall = ~i_dmem_ack & ~timeout_hit;
            if (i_dmem_ack) begin
               req_d   = 1'b0;
               we_d    = 1'b0;
               be_d    = '0;
               state_d = IDLE;
               if (load_q) mem_d = rdata_fmt;
            end else if (timeout_hit) begin
               req_d     = 1'b0;
               we_d      = 1'b0;
               be_d      = '0;
               bus_err_d = 1'b1;
               state_d   = IDLE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
      if (!nrst) o_stall = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         state_q    <= IDLE;
         req_q      <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         be_q       <= '0;
         wdata_q    <= '0;
         size_q     <= '0;
         lane_q     <= '0;
         uns_q      <= 1'b0;
         load_q     <= 1'b0;
         cnt_q      <= '0;
         mem_q      <= '0;
         misalign_q <= 1'b0;
         bus_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         req_q      <= req_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         be_q       <= be_d;
         wdata_q    <= wdata_d;
         size_q     <= size_d;
         lane_q     <= lane_d;
         uns_q      <= uns_d;
         load_q     <= load_d;
         cnt_q      <= cnt_d;
         mem_q      <= mem_d;
         misalign_q <= misalign_d;
         bus_err_q  <= bus_err_d;
      end
   end

   assign o_dmem_req         = req_q;
   assign o_dmem_we          = we_q;
   assign o_dmem_addr        = addr_q;
   assign o_dmem_be          = be_q;
   assign o_dmem_wdata       = wdata_q;
   assign o_MEM_data_MemData = mem_q;
   assign o_misalign         = misalign_q;
   assign o_bus_err          = bus_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: expected load data is queued when a
// load is issued and compared when the access completes.
module tb_mem_access_unit;

   localparam int TO = 20;

   logic        clk = 1'b0;
   logic        nrst;
   logic        rd, wr, uns, ack;
   logic [1:0]  sz;
   logic [31:0] addr, wd, rdata;
   logic        req, we, stall, misalign, bus_err;
   logic [31:0] daddr, dwdata, memdata;
   logic [3:0]  be;

   int          n_chk = 0;
   int          n_err = 0;
   logic [31:0] exp_q[$];
   logic [31:0] last_mem;

   always #5 clk = ~clk;

   mem_access_unit #(.TIMEOUT(TO)) dut (
      .clk                 (clk),
      .nrst                (nrst),
      .i_MEM_ctrl_MemRead  (rd),
      .i_MEM_ctrl_MemWrite (wr),
      .i_MEM_ctrl_Size     (sz),
      .i_MEM_ctrl_Unsigned (uns),
      .i_MEM_data_Addr     (addr),
      .i_MEM_data_WData    (wd),
      .o_dmem_req          (req),
      .o_dmem_we           (we),
      .o_dmem_addr         (daddr),
      .o_dmem_be           (be),
      .o_dmem_wdata        (dwdata),
      .i_dmem_ack          (ack),
      .i_dmem_rdata        (rdata),
      .o_MEM_data_MemData  (memdata),
      .o_stall             (stall),
      .o_misalign          (misalign),
      .o_bus_err           (bus_err)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] model_load(input logic [1:0] s, input logic u,
                                              input logic [31:0] a, input logic [31:0] d);
      logic [7:0]  b;
      logic [15:0] h;
      case (a[1:0])
         2'd0:    b = d[7:0];
         2'd1:    b = d[15:8];
         2'd2:    b = d[23:16];
         default: b = d[31:24];
      endcase
      h = a[1] ? d[31:16] : d[15:0];
      case (s)
         2'd0:    return u ? {24'h0, b} : {{24{b[7]}}, b};
         2'd1:    return u ? {16'h0, h} : {{16{h[15]}}, h};
         default: return d;
      endcase
   endfunction

   function automatic logic [3:0] model_be(input logic [1:0] s, input logic [31:0] a);
      case (s)
         2'd0: case (a[1:0])
                  2'd0:    return 4'b0001;
                  2'd1:    return 4'b0010;
                  2'd2:    return 4'b0100;
                  default: return 4'b1000;
               endcase
         2'd1:    return a[1] ? 4'b1100 : 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] model_wdata(input logic [1:0] s, input logic [31:0] w);
      case (s)
         2'd0:    return {w[7:0], w[7:0], w[7:0], w[7:0]};
         2'd1:    return {w[15:0], w[15:0]};
         default: return w;
      endcase
   endfunction

   // One aligned access; ack arrives in the lat-th request cycle.
   task automatic do_access(input logic r, input logic w, input logic [1:0] s, input logic u,
                            input logic [31:0] a, input logic [31:0] wdv,
                            input logic [31:0] rdv, input int lat);
      int  stalls = 0;
      logic is_load;
      is_load = r & ~w;
      @(posedge clk); #1;
      rd = r; wr = w; sz = s; uns = u; addr = a; wd = wdv;
      @(negedge clk);
      if (stall) stalls++;
      chk("req_before", 32'(req), 32'd0);
      if (is_load) exp_q.push_back(model_load(s, u, a, rdv));
      for (int k = 1; k <= lat; k++) begin
         @(posedge clk); #1;
         if (k == lat) begin
            ack = 1'b1;
            rdata = rdv;
         end
         @(negedge clk);
         if (k == 1) begin
            chk("req", 32'(req), 32'd1);
            chk("we", 32'(we), 32'(w));
            chk("addr", daddr, {a[31:2], 2'b00});
            chk("be", 32'(be), 32'(model_be(s, a)));
            if (w) chk("wdata", dwdata, model_wdata(s, wdv));
         end
         if (stall) stalls++;
      end
      @(posedge clk); #1;
      ack = 1'b0; rd = 1'b0; wr = 1'b0;
      @(negedge clk);
      chk("req_after", 32'(req), 32'd0);
      chk("stall_cycles", 32'(stalls), 32'(lat));
      if (is_load) begin
         if (exp_q.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
         end else begin
            last_mem = exp_q.pop_front();
            chk("memdata", memdata, last_mem);
         end
      end else begin
         chk("memdata_hold", memdata, last_mem);
      end
   endtask

   initial begin
      int          kk;
      int          stalls;
      logic [1:0]  rs;
      logic [31:0] ra;
      nrst = 1'b0; rd = 1'b0; wr = 1'b0; sz = 2'd0; uns = 1'b0;
      addr = '0; wd = '0; rdata = '0; ack = 1'b0;
      last_mem = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_stall", 32'(stall), 32'd0);
      #1 nrst = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst_req", 32'(req), 32'd0);
      chk("rst_addr", daddr, 32'd0);
      chk("rst_be", 32'(be), 32'd0);
      chk("rst_mem", memdata, 32'd0);
      chk("rst_flags", {30'd0, misalign, bus_err}, 32'd0);
      chk("idle_stall", 32'(stall), 32'd0);

      // Stray ack in IDLE
      @(posedge clk); #1 ack = 1'b1; rdata = 32'h12345678;
      @(posedge clk); #1 ack = 1'b0;
      @(negedge clk);
      chk("idle_ack_req", 32'(req), 32'd0);
      chk("idle_ack_mem", memdata, 32'd0);

      do_access(1, 0, 2'd2, 0, 32'h1004, 32'h0, 32'hCAFEF00D, 1);
      do_access(1, 0, 2'd0, 0, 32'h1003, 32'h0, 32'h80112233, 4);
      do_access(1, 0, 2'd1, 1, 32'h2002, 32'h0, 32'h9ABC1234, 2);
      do_access(0, 1, 2'd0, 0, 32'h3001, 32'h000000A5, 32'hFFFFFFFF, 2);
      do_access(0, 1, 2'd1, 0, 32'h3002, 32'h1234BEEF, 32'h0, 1);
      do_access(1, 1, 2'd2, 0, 32'h0010, 32'hDEADBEEF, 32'h55555555, 1);
      do_access(1, 0, 2'd1, 0, 32'h0000, 32'h0, 32'h00008001, 3);
      do_access(1, 0, 2'd3, 1, 32'h0020, 32'h0, 32'h87654321, 1);
      for (int i = 0; i < 6; i++) begin
         rs = 2'($urandom_range(0, 3));
         ra = $urandom;
         if (rs == 2'd1) ra[0] = 1'b0;
         if (rs[1]) ra[1:0] = 2'b00;
         do_access(1, 0, rs, 1'($urandom_range(0, 1)), ra, 32'h0, $urandom,
                   int'($urandom_range(1, 3)));
      end

      // Misaligned half load
      @(posedge clk); #1;
      rd = 1'b1; sz = 2'd1; uns = 1'b0; addr = 32'h4001;
      @(negedge clk);
      chk("mis_stall", 32'(stall), 32'd0);
      @(posedge clk); #1 rd = 1'b0;
      @(negedge clk);
      chk("mis_pulse", 32'(misalign), 32'd1);
      chk("mis_req", 32'(req), 32'd0);
      chk("mis_mem", memdata, last_mem);
      @(posedge clk); #1;
      @(negedge clk);
      chk("mis_pulse_end", 32'(misalign), 32'd0);

      // Timeout: no ack ever
      stalls = 0;
      @(posedge clk); #1;
      rd = 1'b1; sz = 2'd2; addr = 32'h5000;
      @(negedge clk);
      if (stall) stalls++;
      kk = 0;
      for (int k = 1; k <= TO + 4; k++) begin
         @(posedge clk); #1;
         @(negedge clk);
         kk = k;
         if (!stall) break;
         stalls++;
      end
      chk("to_cycles", 32'(kk), 32'(TO));
      chk("to_stalls", 32'(stalls), 32'(TO));
      @(posedge clk); #1 rd = 1'b0;
      @(negedge clk);
      chk("to_req", 32'(req), 32'd0);
      chk("to_buserr", 32'(bus_err), 32'd1);
      chk("to_mem", memdata, last_mem);
      @(posedge clk); #1;
      @(negedge clk);
      chk("to_buserr_end", 32'(bus_err), 32'd0);

      // Reset while BUSY, then a late ack
      @(posedge clk); #1;
      rd = 1'b1; sz = 2'd2; addr = 32'h6000;
      @(posedge clk); #1;
      rd = 1'b0;
      @(negedge clk);
      chk("rb_req", 32'(req), 32'd1);
      #1 nrst = 1'b0;
      #1 chk("rb_stall", 32'(stall), 32'd0);
      @(posedge clk); #1 nrst = 1'b1;
      @(negedge clk);
      chk("rb_req_drop", 32'(req), 32'd0);
      @(posedge clk); #1 ack = 1'b1; rdata = 32'hA5A5A5A5;
      @(posedge clk); #1 ack = 1'b0;
      @(negedge clk);
      chk("rb_late_ack", memdata, 32'd0);
      chk("rb_late_req", 32'(req), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Data-memory access stage of the five-stage MIPS pipeline, sitting between the EX/MEM pipeline register and the MEM/WB pipeline register. Takes load/store control and the ALU-computed address from EX/MEM, runs a request/acknowledge transaction on the data-memory port, and stalls the pipeline until the access completes. Load data is aligned, sign- or zero-extended, and registered on the completion edge. This is the value MEM/WB passes straight through to writeback as MemData, alongside its own registered ALUData.

## Interface
- TIMEOUT, 200: max req-high cycles without ack before abort (2..255).
- clk  in  1  pipeline clock, rising edge.
- nrst  in  1  synchronous active-low reset, sampled on rising clk.
- i_MEM_ctrl_MemRead  in  1  load request.
- i_MEM_ctrl_MemWrite  in  1  store request.
- i_MEM_ctrl_Size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word).
- i_MEM_ctrl_Unsigned  in  1  1 = zero-extend loads, 0 = sign-extend.
- i_MEM_data_Addr  in  32  byte address from ALU.
- i_MEM_data_WData  in  32  store data (rt), right-justified.
- o_dmem_req  out  1  bus request, registered.
- o_dmem_we  out  1  1 = write.
- o_dmem_addr  out  32  word address, {Addr[31:2],2'b00}.
- o_dmem_be  out  4  byte enables.
- o_dmem_wdata  out  32  lane-replicated store data.
- i_dmem_ack  in  1  one-cycle completion, valid only while o_dmem_req=1.
- i_dmem_rdata  in  32  read word, valid with ack.
- o_MEM_data_MemData  out  32  formatted load data, registered, held until next load completes.
- o_stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM; MEM/WB is fed the current values.
- o_misalign  out  1  one-cycle pulse, misaligned access rejected.
- o_bus_err  out  1  one-cycle pulse, access aborted on timeout.

## Operation
- FSM states IDLE, BUSY. Reset: IDLE.
- access = MemRead | MemWrite. Both high: the access is a store. No read data is updated.
- Misaligned: half with Addr[0]=1, or word/reserved with Addr[1:0]!=0.
- IDLE, access, aligned:
  - o_stall=1 combinationally.
  - At the edge, latch req=1, we, addr, be and wdata; clear the timeout counter; go to BUSY.
- IDLE, access, misaligned:
  - No request, o_stall=0.
  - o_misalign=1 in the next cycle for one cycle.
  - MemData unchanged.
- BUSY:
  - Inputs ignored, because the upstream stages are frozen.
  - o_stall = ~i_dmem_ack & ~timeout_hit.
  - ack: drop req/we/be, and go to IDLE at the same edge.
  - On a load ack, also write the formatted rdata into MemData at that edge.
  - No ack: increment the counter.
  - timeout_hit = (counter == TIMEOUT-1) & ~ack: abort at the edge, drop req, go to IDLE, pulse o_bus_err next cycle, MemData unchanged.
  - Ack in the timeout cycle: ack wins, no error.
- Store formatting:
  - Byte: be = 4'b0001 << Addr[1:0], wdata = {4{WData[7:0]}}.
  - Half: be = Addr[1] ? 4'b1100 : 4'b0011, wdata = {2{WData[15:0]}}.
  - Word: be = 4'b1111, wdata = WData.
- Load formatting:
  - Byte lane rdata[8*Addr[1:0]+:8]; half lane rdata[16*Addr[1]+:16]; extended per Unsigned.
  - Uses the address latched at request time.
- i_dmem_ack in IDLE is ignored.

## Timing
- Reset values: all o_dmem_* = 0, MemData = 0, o_misalign = 0, o_bus_err = 0, counter = 0, state IDLE.
- o_stall = 0 whenever nrst = 0.
- Reset mid-transaction: req drops at the reset edge; any late ack is ignored.
- Access accepted in cycle N (stall=1):
  - req high from N+1.
  - Earliest ack at N+1 (stall=0 in N+1).
  - Pipeline advances at the end of N+1.
  - MemData is valid from N+2, aligned with the MEM/WB register outputs.
- Minimum memory-op penalty: 1 stall cycle. Each cycle of ack latency beyond that adds one stall cycle.
- Back-to-back accesses: the new access is seen in IDLE in the cycle after ack. req has a one-cycle gap between transactions.
- Non-memory instructions: o_stall=0, zero latency. MemData holds its last load value.

## Test plan
- Reset, then idle: all outputs 0, o_stall=0; an ack pulse in IDLE changes nothing.
- Load word, Addr=0x1004, rdata=0xCAFEF00D, ack at first req cycle:
  - o_dmem_addr=0x1004, be=4'b1111, stall high 1 cycle.
  - MemData=0xCAFEF00D the following cycle.
- Signed byte load, Addr=0x1003, rdata=0x80112233, ack after 3 cycles: MemData=0xFFFFFF80, stall high 4 cycles.
- Unsigned half load, Addr=0x2002, rdata=0x9ABC1234: MemData=0x00009ABC.
- Store byte, Addr=0x3001, WData=0x000000A5: we=1, be=4'b0010, wdata=0xA5A5A5A5, MemData unchanged.
- Edge cases:
  - Half load at Addr=0x4001: no req, o_misalign single pulse, stall 0.
  - Load with no ack: o_bus_err pulse after TIMEOUT req cycles, req drops.
  - nrst low while BUSY: req=0 next cycle.
